rule_conf_multi_stage: RTL

- Configuration front-end for a chain of STAGE_NUM parser/deparser stages.
- Decodes a 32b register-write bus into per-stage type-rule fields and holds them in a shadow bank.
- Copies the shadow bank atomically into the active bank on a commit, but only when the target stage reports idle, so in-flight packets never see a half-written rule set.
- Provides readback of shadow contents and commit status over the same bus.

---
 rtl/rule_conf_multi_stage_if.sv | 27 ++
 rtl/rule_conf_multi_stage.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rule_conf_multi_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : rule_conf_multi_stage_if
// Brief    : 32b register read/write bus between a configuration master and
//            the rule_conf_multi_stage front-end.
// Revision : 1.0 - initial release
// ============================================================================
interface rule_conf_multi_stage_if;
  logic        i_rule_wren;
  logic [31:0] i_rule_wdata;
  logic [31:0] i_rule_addr;
  logic        o_rule_ready;
  logic        i_rule_rden;
  logic [31:0] o_rule_rdata;
  logic        o_rule_rvalid;

  modport master (
    output i_rule_wren, i_rule_wdata, i_rule_addr, i_rule_rden,
    input  o_rule_ready, o_rule_rdata, o_rule_rvalid
  );

  modport slave (
    input  i_rule_wren, i_rule_wdata, i_rule_addr, i_rule_rden,
    output o_rule_ready, o_rule_rdata, o_rule_rvalid
  );
endinterface
`default_nettype wire

// File: rtl/rule_conf_multi_stage.sv
`default_nettype none
// ============================================================================
// Module   : rule_conf_multi_stage
// Brief    : Register-bus configuration front-end for a chain of parser
//            stages. Writes land in a shadow bank; a commit copies the shadow
//            bank of one stage into its active bank once that stage is idle.
//            Optional macro RULE_CONF_COMMIT_CNT_EN adds a 16b per-stage
//            commit counter reported in the status (class 7) read.
// Revision : 1.0 - initial release
// ============================================================================
module rule_conf_multi_stage #(
  parameter int STAGE_NUM         = 4,
  parameter int RULE_NUM          = 8,
  parameter int TYPE_NUM          = 4,
  parameter int TYPE_WIDTH        = 16,
  parameter int TYPE_OFFSET_WIDTH = 7,
  parameter int KEY_FIELD_NUM     = 8,
  parameter int KEY_OFFSET_WIDTH  = 7,
  parameter int HEAD_SHIFT_WIDTH  = 7,
  parameter int META_SHIFT_WIDTH  = 5
) (
  input  wire                                                  i_clk,
  input  wire                                                  i_rst_n,
  rule_conf_multi_stage_if.slave                               bus,
  input  wire  [STAGE_NUM-1:0]                                 i_stage_idle,
  output logic [STAGE_NUM*RULE_NUM-1:0]                        o_typeRule_wren,
  output logic [STAGE_NUM-1:0]                                 o_typeRule_valid,
  output logic [STAGE_NUM*TYPE_NUM*TYPE_WIDTH-1:0]             o_typeData,
  output logic [STAGE_NUM*TYPE_NUM*TYPE_WIDTH-1:0]             o_typeMask,
  output logic [STAGE_NUM*TYPE_NUM*TYPE_OFFSET_WIDTH-1:0]      o_typeOffset,
  output logic [STAGE_NUM*KEY_FIELD_NUM*(KEY_OFFSET_WIDTH+1)-1:0] o_keyOffset,
  output logic [STAGE_NUM*HEAD_SHIFT_WIDTH-1:0]                o_headShift,
  output logic [STAGE_NUM*META_SHIFT_WIDTH-1:0]                o_metaShift,
  output logic [STAGE_NUM-1:0]                                 o_commit_done
);

  localparam int c_key_w = KEY_OFFSET_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_COPY = 2'd2
  } state_t;

  // Shadow and active banks, packed so the flat output layout is stage-major.
  logic [STAGE_NUM-1:0][TYPE_NUM-1:0][TYPE_WIDTH-1:0]        r_sh_tdata, r_ac_tdata;
  logic [STAGE_NUM-1:0][TYPE_NUM-1:0][TYPE_WIDTH-1:0]        r_sh_tmask, r_ac_tmask;
  logic [STAGE_NUM-1:0][TYPE_NUM-1:0][TYPE_OFFSET_WIDTH-1:0] r_sh_toff,  r_ac_toff;
  logic [STAGE_NUM-1:0][KEY_FIELD_NUM-1:0][c_key_w-1:0]      r_sh_koff,  r_ac_koff;
  logic [STAGE_NUM-1:0][HEAD_SHIFT_WIDTH-1:0]                r_sh_hs,    r_ac_hs;
  logic [STAGE_NUM-1:0][META_SHIFT_WIDTH-1:0]                r_sh_ms,    r_ac_ms;

  logic [STAGE_NUM-1:0][RULE_NUM-1:0] r_rule_wren;
  logic [STAGE_NUM-1:0]               r_rule_valid;
  logic [STAGE_NUM-1:0]               r_commit_done;
  logic [STAGE_NUM-1:0]               r_pending;
  state_t                             r_state [STAGE_NUM];
  logic [31:0]                        r_rdata;
  logic                               r_rvalid;

  logic [2:0]  w_stage, w_class;
  logic [5:0]  w_idx;
  logic [31:0] w_stage_n, w_idx_n, w_idx_lim;
  logic        w_ready, w_addr_ok, w_wr_hit, w_rd_acc, w_commit_req;
  logic [31:0] w_rd_value;
  logic        w_unused;

  assign w_stage   = bus.i_rule_addr[14:12];
  assign w_class   = bus.i_rule_addr[10:8];
  assign w_idx     = bus.i_rule_addr[5:0];
  assign w_stage_n = 32'(w_stage);
  assign w_idx_n   = 32'(w_idx);
  assign w_unused  = ^{bus.i_rule_addr[31:15], bus.i_rule_addr[11], bus.i_rule_addr[7:6]};

  // Number of addressable entries in the selected field class.
  always_comb begin
    w_idx_lim = 32'd1;
    case (w_class)
      3'd0:      w_idx_lim = RULE_NUM;
      3'd1, 3'd2: w_idx_lim = TYPE_NUM;
      3'd3:      w_idx_lim = KEY_FIELD_NUM;
      default:   w_idx_lim = 32'd1;
    endcase
  end

  // The bus stalls while any stage has a commit in flight so that shadow
  // contents cannot change between the commit request and the copy.
  assign w_ready      = ~|r_pending;
  assign w_addr_ok    = (w_stage_n < 32'(STAGE_NUM)) && (w_idx_n < w_idx_lim);
  assign w_wr_hit     = bus.i_rule_wren & w_ready & w_addr_ok;
  assign w_rd_acc     = bus.i_rule_rden & ~bus.i_rule_wren & w_ready;
  assign w_commit_req = w_wr_hit & (w_class == 3'd6) & bus.i_rule_wdata[0];

`ifdef RULE_CONF_COMMIT_CNT_EN
  logic [15:0] r_commit_cnt [STAGE_NUM];

  // Per-stage commit counter, advanced by each commit-done pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < STAGE_NUM; s++) r_commit_cnt[s] <= 16'd0;
    end else begin
      for (int s = 0; s < STAGE_NUM; s++)
        if (r_commit_done[s]) r_commit_cnt[s] <= r_commit_cnt[s] + 16'd1;
    end
  end
`endif

  // Shadow bank updates from accepted writes (classes 1..5).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sh_tdata <= '0;
      r_sh_tmask <= '0;
      r_sh_toff  <= '0;
      r_sh_koff  <= '0;
      r_sh_hs    <= '0;
      r_sh_ms    <= '0;
    end else if (w_wr_hit) begin
      for (int s = 0; s < STAGE_NUM; s++) begin
        if (w_stage_n == 32'(s)) begin
          case (w_class)
            3'd1: for (int i = 0; i < TYPE_NUM; i++)
              if (w_idx_n == 32'(i)) begin
                r_sh_tdata[s][i] <= bus.i_rule_wdata[16 +: TYPE_WIDTH];
                r_sh_tmask[s][i] <= bus.i_rule_wdata[0 +: TYPE_WIDTH];
              end
            3'd2: for (int i = 0; i < TYPE_NUM; i++)
              if (w_idx_n == 32'(i)) r_sh_toff[s][i] <= bus.i_rule_wdata[0 +: TYPE_OFFSET_WIDTH];
            3'd3: for (int i = 0; i < KEY_FIELD_NUM; i++)
              if (w_idx_n == 32'(i))
                r_sh_koff[s][i] <= {bus.i_rule_wdata[16], bus.i_rule_wdata[0 +: KEY_OFFSET_WIDTH]};
            3'd4: r_sh_hs[s] <= bus.i_rule_wdata[0 +: HEAD_SHIFT_WIDTH];
            3'd5: r_sh_ms[s] <= bus.i_rule_wdata[0 +: META_SHIFT_WIDTH];
            default: ;
          endcase
        end
      end
    end
  end

  // Class 0 writes bypass the shadow bank and emit a one-cycle rule strobe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rule_wren  <= '0;
      r_rule_valid <= '0;
    end else begin
      r_rule_wren <= '0;
      if (w_wr_hit && w_class == 3'd0) begin
        for (int s = 0; s < STAGE_NUM; s++) begin
          if (w_stage_n == 32'(s)) begin
            r_rule_valid[s] <= bus.i_rule_wdata[0];
            for (int r = 0; r < RULE_NUM; r++)
              if (w_idx_n == 32'(r)) r_rule_wren[s][r] <= 1'b1;
          end
        end
      end
    end
  end

  // Readback mux: shadow value in write layout; unmapped addresses read 0.
  always_comb begin
    w_rd_value = '0;
    if (w_addr_ok) begin
      for (int s = 0; s < STAGE_NUM; s++) begin
        if (w_stage_n == 32'(s)) begin
          case (w_class)
            3'd1: for (int i = 0; i < TYPE_NUM; i++)
              if (w_idx_n == 32'(i)) w_rd_value = 32'({r_sh_tdata[s][i], r_sh_tmask[s][i]});
            3'd2: for (int i = 0; i < TYPE_NUM; i++)
              if (w_idx_n == 32'(i)) w_rd_value = 32'(r_sh_toff[s][i]);
            3'd3: for (int i = 0; i < KEY_FIELD_NUM; i++)
              if (w_idx_n == 32'(i)) begin
                w_rd_value[16]                   = r_sh_koff[s][i][c_key_w-1];
                w_rd_value[KEY_OFFSET_WIDTH-1:0] = r_sh_koff[s][i][KEY_OFFSET_WIDTH-1:0];
              end
            3'd4: w_rd_value = 32'(r_sh_hs[s]);
            3'd5: w_rd_value = 32'(r_sh_ms[s]);
`ifdef RULE_CONF_COMMIT_CNT_EN
            3'd7: w_rd_value = {r_commit_cnt[s], 8'h00, 8'(r_pending)};
`else
            3'd7: w_rd_value = 32'(r_pending);
`endif
            default: ;
          endcase
        end
      end
    end
  end

  // Read response registered one cycle after acceptance.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_rd_acc;
      if (w_rd_acc) r_rdata <= w_rd_value;
    end
  end

  // Per-stage commit FSM: wait for the stage to go idle, then copy the
  // whole shadow bank of that stage into the active bank in one cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ac_tdata    <= '0;
      r_ac_tmask    <= '0;
      r_ac_toff     <= '0;
      r_ac_koff     <= '0;
      r_ac_hs       <= '0;
      r_ac_ms       <= '0;
      r_commit_done <= '0;
      r_pending     <= '0;
      for (int s = 0; s < STAGE_NUM; s++) r_state[s] <= ST_IDLE;
    end else begin
      for (int s = 0; s < STAGE_NUM; s++) begin
        r_commit_done[s] <= 1'b0;
        case (r_state[s])
          ST_IDLE: if (w_commit_req && w_stage_n == 32'(s)) begin
            r_state[s]   <= ST_PEND;
            r_pending[s] <= 1'b1;
          end
          ST_PEND: if (i_stage_idle[s]) r_state[s] <= ST_COPY;
          ST_COPY: begin
            r_ac_tdata[s]    <= r_sh_tdata[s];
            r_ac_tmask[s]    <= r_sh_tmask[s];
            r_ac_toff[s]     <= r_sh_toff[s];
            r_ac_koff[s]     <= r_sh_koff[s];
            r_ac_hs[s]       <= r_sh_hs[s];
            r_ac_ms[s]       <= r_sh_ms[s];
            r_commit_done[s] <= 1'b1;
            r_pending[s]     <= 1'b0;
            r_state[s]       <= ST_IDLE;
          end
          default: r_state[s] <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.o_rule_ready  = w_ready;
  assign bus.o_rule_rdata  = r_rdata;
  assign bus.o_rule_rvalid = r_rvalid;
  assign o_typeRule_wren   = r_rule_wren;
  assign o_typeRule_valid  = r_rule_valid;
  assign o_typeData        = r_ac_tdata;
  assign o_typeMask        = r_ac_tmask;
  assign o_typeOffset      = r_ac_toff;
  assign o_keyOffset       = r_ac_koff;
  assign o_headShift       = r_ac_hs;
  assign o_metaShift       = r_ac_ms;
  assign o_commit_done     = r_commit_done;

endmodule
`default_nettype wire
